front_panel_input: RTL
======================

Name: front_panel_input

Overview:
Input-side conditioner for the board front panel: the raw push-button and slide switches feeding the game logic and the 7-seg display path.
- Synchronises and debounces the button and every switch.
- Emits single-cycle press, release and long-press events.
- Captures a switch snapshot at each press, so game logic consumes exactly one coherent guess per press instead of a raw button level.

Parameters:
SW_WIDTH, 10, number of slide switches
DEBOUNCE_CYCLES, 1000000, cycles an input must hold a new value before it is accepted (20 ms at 50 MHz); must be >= 2
LONG_CYCLES, 100000000, cycles of continuous debounced press before oBtn_long fires (2 s at 50 MHz); must be >= 2
BTN_ACTIVE_LOW, 1, 1 = iBtn is low when pressed (KEY pins); 0 = high when pressed

Ports:
iClk  input  1  system clock; the only clock
iRst_n  input  1  asynchronous active-low reset
iBtn  input  1  raw push-button, asynchronous to iClk
iSwitch  input  SW_WIDTH  raw slide switches, asynchronous to iClk
oBtn_level  output  1  debounced button, 1 = pressed (polarity normalised)
oBtn_pulse  output  1  one-cycle pulse on debounced press
oBtn_release  output  1  one-cycle pulse on debounced release
oBtn_long  output  1  one-cycle pulse when the press has lasted LONG_CYCLES
oSwitch  output  SW_WIDTH  debounced switch values
oSwitch_snap  output  SW_WIDTH  oSwitch value captured at the last oBtn_pulse
oSwitch_chg  output  1  one-cycle pulse whenever any oSwitch bit changes

Behaviour:
Reset (async, iRst_n=0):
- All outputs 0; sync flops 0.
- Debounced button state = released; debounced switches = 0.
- Counters 0; FSM = ST_IDLE.
- Reset mid-debounce or mid-press discards all progress.

Input path (per bit, identical for button after polarity normalisation):
- 2-flop synchroniser, then debounce.
- Debounce counter width = $clog2(DEBOUNCE_CYCLES).
- If synced value == stable value: counter cleared.
- Otherwise: counter increments each cycle.
- When counter == DEBOUNCE_CYCLES-1 and the mismatch persists, stable value takes the synced value and the counter clears.
- Any bounce back to the stable value clears the counter.
- Latency: a raw input held constant from before edge 1 updates the stable value at edge DEBOUNCE_CYCLES+2.
- A glitch shorter than DEBOUNCE_CYCLES cycles never changes the output.

Switch outputs:
- oSwitch = stable switch bits.
- oSwitch_chg is registered and is 1 in the cycle after any stable switch bit updates.
- Several bits updating on the same edge give one pulse.

Button FSM (states ST_IDLE, ST_PRESSED, ST_LONG):
- ST_IDLE, stable button rises: oBtn_pulse=1 for exactly the next cycle; oSwitch_snap <= oSwitch (the pre-edge value, so a switch update on the same edge is not captured); hold counter cleared; go to ST_PRESSED.
- ST_PRESSED: hold counter increments each cycle.
  - At LONG_CYCLES-1: oBtn_long=1 for one cycle; go to ST_LONG.
  - On release: oBtn_release pulse; go to ST_IDLE.
- ST_LONG: hold counter frozen; on release, oBtn_release pulse and go to ST_IDLE. oBtn_long fires at most once per press.
- oBtn_level, oBtn_pulse, oBtn_release and oBtn_long are all registered and asserted in the same cycle for a given event.
- A pulse is never longer than one cycle.
- A button held during reset deassertion produces a normal oBtn_pulse once debounced.
- Hold counter width = $clog2(LONG_CYCLES).

Decomposition:
- Shared package fp_pkg:
  - FSM state typedef/localparams (ST_IDLE=2'd0, ST_PRESSED=2'd1, ST_LONG=2'd2).
  - Default cycle constants for 50 MHz.
- Sub-module debounce_bit (sync + counter + stable flop, DEBOUNCE_CYCLES parameter), instantiated SW_WIDTH+1 times via generate.
- Top module holds polarity inversion, the event FSM, the snapshot and change detection.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, LONG_CYCLES=20, SW_WIDTH=10, BTN_ACTIVE_LOW=1.)
1. Reset with iBtn=1, iSwitch=10'h3FF held -> all outputs 0 during reset; oSwitch=10'h3FF at edge 6 after release; oSwitch_chg pulses once; no button events.
2. iBtn driven 0 for 3 cycles then 1, repeated 5 times -> oBtn_level stays 0; no pulses.
3. iSwitch=10'b1101010011 settled, iBtn=0 held 30 cycles then 1 -> oBtn_pulse exactly one cycle, 6 edges after the fall; oSwitch_snap=10'b1101010011; oBtn_long once 20 cycles after the pulse; oBtn_release once after release plus debounce.
4. Press held 10 cycles then released -> oBtn_pulse and oBtn_release fire, oBtn_long never fires.
5. Switch edge and button press arranged to debounce on the same edge -> oSwitch_snap holds the old switch value; oSwitch shows the new value.
6. iRst_n pulsed low while in ST_PRESSED with hold count 15 -> all outputs 0 immediately; button still held after reset gives a fresh oBtn_pulse 6 edges later and oBtn_long 20 cycles after that.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the front-panel input conditioner: button FSM states
// and default timing constants for a 50 MHz system clock.
package fp_pkg;

  localparam int DEF_SW_WIDTH        = 10;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms at 50 MHz
  localparam int DEF_LONG_CYCLES     = 100_000_000; // 2 s at 50 MHz

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } btnState_t;

endpackage

// File: rtl/front_panel_input_if.sv
// Front-panel signal bundle: raw panel inputs in, conditioned levels and events out.
interface front_panel_input_if #(
  parameter int SW_WIDTH = 10
);

  logic                iBtn;
  logic [SW_WIDTH-1:0] iSwitch;
  logic                oBtn_level;
  logic                oBtn_pulse;
  logic                oBtn_release;
  logic                oBtn_long;
  logic [SW_WIDTH-1:0] oSwitch;
  logic [SW_WIDTH-1:0] oSwitch_snap;
  logic                oSwitch_chg;

  modport master (
    output iBtn, iSwitch,
    input  oBtn_level, oBtn_pulse, oBtn_release, oBtn_long,
    input  oSwitch, oSwitch_snap, oSwitch_chg
  );

  modport slave (
    input  iBtn, iSwitch,
    output oBtn_level, oBtn_pulse, oBtn_release, oBtn_long,
    output oSwitch, oSwitch_snap, oSwitch_chg
  );

endinterface

// File: rtl/front_panel_input_debounce.sv
// One-bit synchroniser and debouncer; oUpdate flags the edge on which the
// stable value is about to flip so the caller can raise events on that same edge.
module debounce_bit
  import fp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iRaw,
  output logic oStable,
  output logic oUpdate
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          syncMeta_r;
  logic          sync_r;
  logic          stable_r;
  logic [CW-1:0] cnt_r;
  logic          mismatch_s;

  // Mismatch detection and accept strobe
  always_comb begin
    mismatch_s = (sync_r != stable_r);
    oUpdate    = mismatch_s && (cnt_r == CNT_LAST);
  end

  // Two-flop synchroniser
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      syncMeta_r <= 1'b0;
      sync_r     <= 1'b0;
    end else begin
      syncMeta_r <= iRaw;
      sync_r     <= syncMeta_r;
    end
  end

  // Hold counter and accepted value; any bounce back restarts the count
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      stable_r <= 1'b0;
      cnt_r    <= '0;
    end else if (!mismatch_s) begin
      cnt_r <= '0;
    end else if (oUpdate) begin
      stable_r <= sync_r;
      cnt_r    <= '0;
    end else begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign oStable = stable_r;

endmodule

// File: rtl/front_panel_input.sv
// Front-panel conditioner: debounced switches and button, press/release/long
// events, and a switch snapshot taken at every press.
module front_panel_input
  import fp_pkg::*;
#(
  parameter int SW_WIDTH        = DEF_SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input logic                 iClk,
  input logic                 iRst_n,
  front_panel_input_if.slave  panel
);

  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic                btnNorm_s;
  logic                btnStable_s;
  logic                btnUpdate_s;
  logic                btnRise_s;
  logic                btnFall_s;
  logic [SW_WIDTH-1:0] swStable_s;
  logic [SW_WIDTH-1:0] swUpdate_s;

  btnState_t           state_r, stateNext_s;
  logic [HW-1:0]       hold_r, holdNext_s;
  logic                pulse_r, pulseNext_s;
  logic                release_r, releaseNext_s;
  logic                long_r, longNext_s;
  logic                snapLoad_s;
  logic [SW_WIDTH-1:0] swSnap_r;
  logic                swChg_r;

  assign btnNorm_s = BTN_ACTIVE_LOW ? ~panel.iBtn : panel.iBtn;

  debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uBtnDb (
    .iClk    (iClk),
    .iRst_n  (iRst_n),
    .iRaw    (btnNorm_s),
    .oStable (btnStable_s),
    .oUpdate (btnUpdate_s)
  );

  for (genvar g = 0; g < SW_WIDTH; g++) begin : gSwDb
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uSwDb (
      .iClk    (iClk),
      .iRst_n  (iRst_n),
      .iRaw    (panel.iSwitch[g]),
      .oStable (swStable_s[g]),
      .oUpdate (swUpdate_s[g])
    );
  end

  // Events are keyed to the edge on which the debounced button flips
  assign btnRise_s = btnUpdate_s & ~btnStable_s;
  assign btnFall_s = btnUpdate_s &  btnStable_s;

  // Button event FSM: next state, hold count and event strobes
  always_comb begin
    stateNext_s   = state_r;
    holdNext_s    = hold_r;
    pulseNext_s   = 1'b0;
    releaseNext_s = 1'b0;
    longNext_s    = 1'b0;
    snapLoad_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (btnRise_s) begin
          pulseNext_s = 1'b1;
          snapLoad_s  = 1'b1;
          holdNext_s  = '0;
          stateNext_s = ST_PRESSED;
        end else begin
          stateNext_s = ST_IDLE;
        end
      end
      ST_PRESSED: begin
        if (btnFall_s) begin
          releaseNext_s = 1'b1;
          stateNext_s   = ST_IDLE;
        end else if (hold_r == HOLD_LAST) begin
          longNext_s  = 1'b1;
          stateNext_s = ST_LONG;
        end else begin
          holdNext_s = hold_r + 1'b1;
        end
      end
      ST_LONG: begin
        if (btnFall_s) begin
          releaseNext_s = 1'b1;
          stateNext_s   = ST_IDLE;
        end else begin
          stateNext_s = ST_LONG;
        end
      end
      default: begin
        stateNext_s = ST_IDLE;
        holdNext_s  = '0;
      end
    endcase
  end

  // FSM registers, event outputs, snapshot and switch-change strobe
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_r   <= ST_IDLE;
      hold_r    <= '0;
      pulse_r   <= 1'b0;
      release_r <= 1'b0;
      long_r    <= 1'b0;
      swSnap_r  <= '0;
      swChg_r   <= 1'b0;
    end else begin
      state_r   <= stateNext_s;
      hold_r    <= holdNext_s;
      pulse_r   <= pulseNext_s;
      release_r <= releaseNext_s;
      long_r    <= longNext_s;
      swChg_r   <= |swUpdate_s;
      // Pre-edge switch value, so a switch settling on the press edge is excluded
      if (snapLoad_s) begin
        swSnap_r <= swStable_s;
      end
    end
  end

  assign panel.oBtn_level   = btnStable_s;
  assign panel.oBtn_pulse   = pulse_r;
  assign panel.oBtn_release = release_r;
  assign panel.oBtn_long    = long_r;
  assign panel.oSwitch      = swStable_s;
  assign panel.oSwitch_snap = swSnap_r;
  assign panel.oSwitch_chg  = swChg_r;

endmodule
